// File: rtl/vga_timing_decoder.sv
// Receive-side VGA timing recovery: rebuilds pixel position from hsync/vsync, measures periods, qualifies lock.
// Optional macro VGA_DEC_SYNC_WIDTH_CHECK_EN adds sync pulse width measurement/checking and hs_width/vs_width ports.
module vga_timing_decoder #(
  parameter int H_DISPLAY   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_DISPLAY   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int LOCK_FRAMES = 2,
  parameter int SYNC_POL    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  output logic [11:0] pixel_x,
  output logic [11:0] pixel_y,
  output logic        video_on,
  output logic        line_start,
  output logic        frame_start,
  output logic        locked,
  output logic [11:0] h_meas,
  output logic [11:0] v_meas,
  output logic [7:0]  err_cnt
`ifdef VGA_DEC_SYNC_WIDTH_CHECK_EN
  ,
  output logic [11:0] hs_width,
  output logic [11:0] vs_width
`endif
);

  localparam int H_TOTAL_I = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL_I = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [11:0] H_TOTAL  = 12'(H_TOTAL_I);
  localparam logic [11:0] V_TOTAL  = 12'(V_TOTAL_I);
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL_I - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL_I - 1);
  localparam logic [11:0] HS_START = 12'(H_DISPLAY + H_FRONT);
  localparam logic [11:0] VS_START = 12'(V_DISPLAY + V_FRONT);
  localparam logic [11:0] H_MISS   = 12'(2 * H_TOTAL_I);
  localparam logic [11:0] H_DISP   = 12'(H_DISPLAY);
  localparam logic [11:0] V_DISP   = 12'(V_DISPLAY);
  localparam logic [3:0]  LOCK_N   = 4'(LOCK_FRAMES);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  generate
    if (H_TOTAL_I >= 2048 || V_TOTAL_I >= 2048 || LOCK_FRAMES < 1 || LOCK_FRAMES > 15) begin : g_bad_cfg
      $error("vga_timing_decoder: timing sums must be < 2048 and LOCK_FRAMES in 1..15");
    end
  endgenerate

  logic        hs_act, vs_act, hs_fall, vs_fall;
  logic        line_err, frame_err, any_err;
  logic        hs_r_q, vs_r_q;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic        line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic [11:0] per_q, per_d, line_q, line_d;
  logic [11:0] h_meas_q, h_meas_d, v_meas_q, v_meas_d;
  logic        h_chk_q, h_chk_d, v_chk_q, v_chk_d;
  logic [1:0]  state_q, state_d;
  logic [3:0]  good_q, good_d;
  logic [7:0]  err_q, err_d;

  // Everything downstream works on active-high sync regardless of source polarity.
  assign hs_act  = (SYNC_POL != 0) ? hsync : ~hsync;
  assign vs_act  = (SYNC_POL != 0) ? vsync : ~vsync;
  assign hs_fall = hs_act & ~hs_r_q;
  assign vs_fall = vs_act & ~vs_r_q;

`ifdef VGA_DEC_SYNC_WIDTH_CHECK_EN
  localparam logic [11:0] H_SYNC_W = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_W = 12'(V_SYNC);
  logic        hs_rise, vs_rise, hw_err, vw_err;
  logic [11:0] hw_q, hw_d, vw_q, vw_d, hs_wid_q, hs_wid_d, vs_wid_q, vs_wid_d;

  assign hs_rise = hs_r_q & ~hs_act;
  assign vs_rise = vs_r_q & ~vs_act;

  always_comb begin
    hw_d     = hw_q;
    vw_d     = vw_q;
    hs_wid_d = hs_wid_q;
    vs_wid_d = vs_wid_q;
    if (hs_fall)                         hw_d = 12'd1;
    else if (hs_act && hw_q != 12'hFFF)  hw_d = hw_q + 12'd1;
    // vsync width is counted in lines, i.e. hsync starts seen while vsync is active
    if (vs_fall)                                   vw_d = hs_fall ? 12'd1 : 12'd0;
    else if (hs_fall && vs_act && vw_q != 12'hFFF) vw_d = vw_q + 12'd1;
    if (hs_rise) hs_wid_d = hw_q;
    if (vs_rise) vs_wid_d = vw_q;
    hw_err = (state_q != ST_SEARCH) && hs_rise && (hw_q != H_SYNC_W);
    vw_err = (state_q != ST_SEARCH) && vs_rise && (vw_q != V_SYNC_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hw_q     <= '0;
      vw_q     <= '0;
      hs_wid_q <= '0;
      vs_wid_q <= '0;
    end else begin
      hw_q     <= hw_d;
      vw_q     <= vw_d;
      hs_wid_q <= hs_wid_d;
      vs_wid_q <= vs_wid_d;
    end
  end

  assign hs_width = hs_wid_q;
  assign vs_width = vs_wid_q;
`else
  logic hw_err, vw_err;
  assign hw_err = 1'b0;
  assign vw_err = 1'b0;
`endif

  always_comb begin
    // position counters: free-running, re-aligned by sync starts
    y_d = y_q;
    if (hs_fall) begin
      x_d = HS_START;
    end else if (x_q >= H_LAST) begin
      x_d = '0;
      y_d = (y_q >= V_LAST) ? 12'd0 : y_q + 12'd1;
    end else begin
      x_d = x_q + 12'd1;
    end
    if (vs_fall) begin
      y_d = VS_START;
      x_d = hs_fall ? HS_START : 12'd0;
    end
    line_start_d  = (x_d == 12'd0);
    frame_start_d = (x_d == 12'd0) && (y_d == 12'd0);

    per_d    = (per_q == 12'hFFF) ? per_q : per_q + 12'd1;
    line_d   = line_q;
    h_meas_d = h_meas_q;
    v_meas_d = v_meas_q;
    if (hs_fall) begin
      h_meas_d = (per_q == 12'hFFF) ? 12'hFFF : per_q + 12'd1;
      per_d    = '0;
      if (line_q != 12'hFFF) line_d = line_q + 12'd1;
    end
    if (vs_fall) begin
      v_meas_d = line_q;
      line_d   = '0;
    end

    // the first period measured after leaving SEARCH is never judged
    h_chk_d = (state_q == ST_SEARCH) ? 1'b0 : (h_chk_q | hs_fall);
    v_chk_d = (state_q == ST_SEARCH) ? 1'b0 : (v_chk_q | vs_fall);

    line_err  = (state_q != ST_SEARCH) &&
                ((hs_fall && h_chk_q && (per_q + 12'd1 != H_TOTAL)) || (per_q == H_MISS) || hw_err);
    frame_err = (state_q != ST_SEARCH) &&
                ((vs_fall && v_chk_q && (line_q != V_TOTAL)) || vw_err);
    any_err   = line_err | frame_err;

    state_d = state_q;
    good_d  = good_q;
    err_d   = err_q;
    case (state_q)
      ST_SEARCH: begin
        if (vs_fall) begin
          state_d = ST_ACQUIRE;
          good_d  = '0;
        end
      end
      ST_ACQUIRE: begin
        if (any_err) begin
          good_d = '0;
        end else if (vs_fall) begin
          good_d = good_q + 4'd1;
          if (good_q + 4'd1 >= LOCK_N) state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (any_err) begin
          err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
          good_d  = '0;
          state_d = ST_ACQUIRE;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_r_q        <= 1'b0;
      vs_r_q        <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      per_q         <= '0;
      line_q        <= '0;
      h_meas_q      <= '0;
      v_meas_q      <= '0;
      h_chk_q       <= 1'b0;
      v_chk_q       <= 1'b0;
      state_q       <= ST_SEARCH;
      good_q        <= '0;
      err_q         <= '0;
    end else begin
      hs_r_q        <= hs_act;
      vs_r_q        <= vs_act;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      per_q         <= per_d;
      line_q        <= line_d;
      h_meas_q      <= h_meas_d;
      v_meas_q      <= v_meas_d;
      h_chk_q       <= h_chk_d;
      v_chk_q       <= v_chk_d;
      state_q       <= state_d;
      good_q        <= good_d;
      err_q         <= err_d;
    end
  end

  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign locked      = (state_q == ST_LOCKED);
  assign video_on    = locked && (x_q < H_DISP) && (y_q < V_DISP);
  assign h_meas      = h_meas_q;
  assign v_meas      = v_meas_q;
  assign err_cnt     = err_q;

endmodule
